// File: rtl/bus_pkg.sv
// Shared types for the bus master port.
// Command codes, FSM encoding and the FIFO request word.
package bus_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    // Widest request the port carries; port widths must not exceed these.
    typedef struct packed {
        logic                  cmd;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_req_fifo.sv
// Command FIFO for the bus master port.
// Also exposes the word that becomes head after a pop.
module bus_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head,
    output logic [W-1:0] head_next,
    output logic         head_next_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign head    = mem[rd_ptr];

    // With a single entry left, the next head is the word arriving now.
    assign head_next = (count > (PW+1)'(1)) ? mem[rd_ptr + PW'(1)] : din;
    assign head_next_valid = (count > (PW+1)'(1)) | do_push;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/bus_master_port.sv
// Initiator-side bus port: queues user commands, issues them on the
// cs/cmd/addr/wdata bus and returns one response per command.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_cmd,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_cmd,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  cs,
    output logic                  cmd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  slave_ack
);

    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]    state;
    logic [CW-1:0] timer;
    bus_req_t      din;
    bus_req_t      head;
    bus_req_t      head_next;
    logic          full;
    logic          empty;
    logic          head_next_valid;
    logic          xfer;
    logic          expire;
    logic          pop;

    assign req_ready = !full;

    assign din.cmd   = req_cmd;
    assign din.addr  = BUS_ADDR_W'(req_addr);
    assign din.wdata = BUS_DATA_W'(req_wdata);

    assign xfer   = (state == ST_REQ) & slave_ack;
    assign expire = (state == ST_REQ) & !slave_ack
                  & (timer == CW'(TIMEOUT - 2));
    assign pop    = xfer | expire;

    bus_req_fifo #(
        .W     ($bits(bus_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .push            (req_valid),
        .pop             (pop),
        .din             (din),
        .full            (full),
        .empty           (empty),
        .head            (head),
        .head_next       (head_next),
        .head_next_valid (head_next_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            timer <= '0;
            cs    <= 1'b0;
            cmd   <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (!empty) begin
                        state <= ST_REQ;
                        cs    <= 1'b1;
                        cmd   <= head.cmd;
                        addr  <= ADDR_WIDTH'(head.addr);
                        wdata <= DATA_WIDTH'(head.wdata);
                    end
                end
                ST_REQ: begin
                    if (slave_ack) begin
                        timer <= '0;
                        if (head_next_valid) begin
                            cmd   <= head_next.cmd;
                            addr  <= ADDR_WIDTH'(head_next.addr);
                            wdata <= DATA_WIDTH'(head_next.wdata);
                        end else begin
                            state <= ST_IDLE;
                            cs    <= 1'b0;
                            cmd   <= 1'b0;
                            addr  <= '0;
                            wdata <= '0;
                        end
                    end else if (expire) begin
                        state <= ST_ABORT;
                        timer <= timer + CW'(1);
                        cs    <= 1'b0;
                        cmd   <= 1'b0;
                        addr  <= '0;
                        wdata <= '0;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                ST_ABORT: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Both completions and aborts retire the head and answer it.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_cmd   <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= pop;
            if (pop) begin
                resp_cmd   <= cmd;
                resp_err   <= expire;
                resp_rdata <= (xfer && cmd == CMD_READ) ? rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: directed vectors,
// multi-cycle corner cases and a randomized scoreboard run.
module tb_bus_master_port;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_cmd = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_cmd;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          cs;
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          slave_ack;

    bus_master_port #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_cmd   (resp_cmd),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .cs         (cs),
        .cmd        (cmd),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .slave_ack  (slave_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        c;
        logic        e;
        logic [31:0] d;
        int          t;
    } resp_rec_t;

    typedef struct {
        logic        c;
        logic [31:0] a;
        logic [31:0] d;
        logic        k;
        int          t;
    } bus_rec_t;

    typedef struct {
        logic        c;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_d;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall = 0;
    int idle_dirty = 0;
    int rd_idx = 0;

    resp_rec_t resp_q[$];
    bus_rec_t  bus_q[$];
    resp_rec_t mon_r;
    bus_rec_t  mon_b;

    logic [31:0] slave_mem [16];
    logic        ack_gate = 1'b0;
    logic        rand_mode = 1'b0;
    logic        rand_ack = 1'b0;

    assign slave_ack = cs & (rand_mode ? rand_ack : ack_gate);
    assign rdata     = slave_mem[addr[3:0]];

    // Slave memory, stall tracking and random ack generation.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < 16; i++) slave_mem[i] <= '0;
        end else if (cs && slave_ack && cmd) begin
            slave_mem[addr[3:0]] <= wdata;
        end
        stall    <= (cs && !slave_ack) ? stall + 1 : 0;
        rand_ack <= (stall >= 7) ? 1'b1 : ($urandom_range(0, 9) < 6);
    end

    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (resp_valid) begin
                mon_r.c = resp_cmd;
                mon_r.e = resp_err;
                mon_r.d = resp_rdata;
                mon_r.t = cyc;
                resp_q.push_back(mon_r);
            end
            if (cs) begin
                mon_b.c = cmd;
                mon_b.a = addr;
                mon_b.d = wdata;
                mon_b.k = slave_ack;
                mon_b.t = cyc;
                bus_q.push_back(mon_b);
            end else if (cmd || addr != '0 || wdata != '0) begin
                idle_dirty = idle_dirty + 1;
            end
        end
    end

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic c, input logic [31:0] a,
                        input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = c;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("push_ready_bound", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output resp_rec_t r);
        int n = 0;
        while (resp_q.size() <= rd_idx && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (resp_q.size() <= rd_idx) begin
            check("resp_wait_bound", resp_q.size(), rd_idx + 1);
            r = '{1'b0, 1'b0, 32'h0, 0};
        end else begin
            r = resp_q[rd_idx];
            rd_idx++;
        end
    endtask

    vec_t      vecs[8];
    resp_rec_t r;
    resp_rec_t exp_q[$];
    logic [31:0] ref_mem [16];
    int b0;
    int r0;
    int n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 32'h4, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b1, 32'h8, 32'h00001234, 32'h0};
        vecs[2] = '{1'b0, 32'h8, 32'h0,        32'h00001234};
        vecs[3] = '{1'b1, 32'h4, 32'h0,        32'h0};
        vecs[4] = '{1'b0, 32'h4, 32'h0,        32'h0};
        vecs[5] = '{1'b0, 32'h9, 32'h0,        32'h0};
        vecs[6] = '{1'b1, 32'h9, 32'hCAFEF00D, 32'h0};
        vecs[7] = '{1'b0, 32'h9, 32'h0,        32'hCAFEF00D};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cs", cs, 0);
        check("rst_ready", req_ready, 1);
        check("rst_resp", {resp_valid, resp_cmd, resp_err, resp_rdata}, 0);
        check("rst_bus", {cmd, addr, wdata}, 0);

        // Single write: latency and response
        ack_gate = 1'b1;
        push(1'b1, 32'h4, 32'hDEADBEEF);
        check("lat_cs_at_push", cs, 0);
        @(posedge clk);
        #1;
        check("lat_bus", {cs, cmd, addr, wdata}, {1'b1, 1'b1, 32'h4, 32'hDEADBEEF});
        @(posedge clk);
        #1;
        check("lat_resp", {resp_valid, resp_cmd, resp_err}, 3'b110);
        repeat (2) @(negedge clk);
        rd_idx = resp_q.size();

        // Table of directed commands, zero-wait slave
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].c, vecs[i].a, vecs[i].d);
            wait_resp(r);
            check("vec_resp", {r.c, r.e, r.d}, {vecs[i].c, 1'b0, vecs[i].exp_d});
        end

        // Back-to-back writes
        repeat (2) @(negedge clk);
        b0 = bus_q.size();
        r0 = resp_q.size();
        for (int i = 0; i < 4; i++) push(1'b1, i, 32'h10 + i);
        repeat (8) @(negedge clk);
        check("b2b_cs_cycles", bus_q.size() - b0, 4);
        for (int i = 0; i < 4 && b0 + i < bus_q.size(); i++) begin
            check("b2b_bus", {bus_q[b0+i].a, bus_q[b0+i].d, bus_q[b0+i].t},
                  {32'(i), 32'h10 + 32'(i), bus_q[b0].t + i});
        end
        check("b2b_resp_count", resp_q.size() - r0, 4);
        for (int i = 0; i < 4 && r0 + i < resp_q.size(); i++) begin
            check("b2b_resp", {resp_q[r0+i].c, resp_q[r0+i].e, resp_q[r0+i].t},
                  {2'b10, resp_q[r0].t + i});
        end
        rd_idx = resp_q.size();

        // Stall: ack low while the read waits
        ack_gate = 1'b0;
        push(1'b0, 32'h8, 32'h0);
        n = 0;
        while (!cs && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {cs, cmd, addr, resp_valid},
                  {1'b1, 1'b0, 32'h8, 1'b0});
            @(negedge clk);
        end
        ack_gate = 1'b1;
        @(negedge clk);
        check("stall_resp", {resp_valid, resp_cmd, resp_err, resp_rdata},
              {3'b100, 32'h1234});
        @(negedge clk);
        check("stall_single", resp_valid, 0);
        #2;
        rd_idx = resp_q.size();

        // Timeout on a dead slave, then the queued write proceeds
        ack_gate = 1'b0;
        b0 = bus_q.size();
        push(1'b0, 32'hC, 32'h0);
        push(1'b1, 32'h5, 32'h55);
        wait_resp(r);
        check("to_resp", {r.c, r.e, r.d}, {2'b01, 32'h0});
        check("to_cs_low", cs, 0);
        ack_gate = 1'b1;
        wait_resp(r);
        check("to_next_resp", {r.c, r.e, r.d}, {2'b10, 32'h0});
        n = 0;
        for (int i = b0; i < bus_q.size(); i++) begin
            if (bus_q[i].a == 32'hC) n++;
        end
        check("to_cs_cycles", n, TO - 1);

        // Full FIFO with a stalled slave
        ack_gate = 1'b0;
        push(1'b1, 32'h1, 32'hA1);
        push(1'b1, 32'h2, 32'hA2);
        push(1'b0, 32'h1, 32'h0);
        check("full_ready_3", req_ready, 1);
        push(1'b0, 32'h2, 32'h0);
        check("full_ready_4", req_ready, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = 1'b1;
        req_addr  = 32'h1;
        req_wdata = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_reject", req_ready, 0);
        end
        req_valid = 1'b0;
        ack_gate  = 1'b1;
        wait_resp(r);
        check("full_drain0", {r.c, r.e, r.d}, {2'b10, 32'h0});
        wait_resp(r);
        check("full_drain1", {r.c, r.e, r.d}, {2'b10, 32'h0});
        wait_resp(r);
        check("full_drain2", {r.c, r.e, r.d}, {2'b00, 32'hA1});
        wait_resp(r);
        check("full_drain3", {r.c, r.e, r.d}, {2'b00, 32'hA2});
        repeat (10) @(negedge clk);
        check("full_no_extra", resp_q.size(), rd_idx);

        // Reset while a transfer is in flight
        ack_gate = 1'b0;
        push(1'b0, 32'h0, 32'h0);
        push(1'b0, 32'h1, 32'h0);
        push(1'b0, 32'h2, 32'h0);
        check("rmid_cs_before", cs, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmid_after", {cs, req_ready, resp_valid}, 3'b010);
        ack_gate = 1'b1;
        #2;
        r0 = resp_q.size();
        b0 = bus_q.size();
        repeat (10) @(negedge clk);
        check("rmid_no_resp", resp_q.size(), r0);
        check("rmid_no_bus", bus_q.size(), b0);
        rd_idx = resp_q.size();

        // Randomized commands against an in-order reference memory
        for (int i = 0; i < 16; i++) ref_mem[i] = slave_mem[i];
        rand_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic        c;
            logic [31:0] a;
            logic [31:0] d;
            c = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15));
            d = $urandom;
            if (c) begin
                ref_mem[a[3:0]] = d;
                exp_q.push_back('{1'b1, 1'b0, 32'h0, 0});
            end else begin
                exp_q.push_back('{1'b0, 1'b0, ref_mem[a[3:0]], 0});
            end
            push(c, a, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        foreach (exp_q[i]) begin
            wait_resp(r);
            check("rand_resp", {r.c, r.e, r.d}, {exp_q[i].c, exp_q[i].e, exp_q[i].d});
        end
        rand_mode = 1'b0;
        repeat (5) @(negedge clk);

        // Bus protocol over the whole run
        for (int i = 1; i < bus_q.size(); i++) begin
            if (bus_q[i].t == bus_q[i-1].t + 1 && !bus_q[i-1].k) begin
                check("bus_stable", {bus_q[i].c, bus_q[i].a, bus_q[i].d},
                      {bus_q[i-1].c, bus_q[i-1].a, bus_q[i-1].d});
            end
        end
        check("bus_idle_zero", idle_dirty, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
